// File: rtl/cci_mpf_sim_fiu_responder.sv
`default_nettype none
// ============================================================================
// Module  : cci_mpf_sim_fiu_responder
// Purpose : FIU-side line-memory responder with almost-full flow control.
// Revision: 1.0 - initial release
// ============================================================================
module cci_mpf_sim_fiu_responder #(
  parameter int ADDR_WIDTH     = 42,
  parameter int MDATA_WIDTH    = 16,
  parameter int MEM_IDX_BITS   = 10,
  parameter int FIFO_DEPTH     = 64,
  parameter int ALM_FULL_SLACK = 8,
  parameter int READ_LATENCY   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c0_req_addr,
  input  logic [MDATA_WIDTH-1:0] c0_req_mdata,
  input  logic                   c1_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c1_req_addr,
  input  logic [MDATA_WIDTH-1:0] c1_req_mdata,
  input  logic [511:0]           c1_req_data,
  output logic                   c0TxAlmFull,
  output logic                   c1TxAlmFull,
  output logic                   c0_rsp_valid,
  output logic [MDATA_WIDTH-1:0] c0_rsp_mdata,
  output logic [511:0]           c0_rsp_data,
  output logic                   c1_rsp_valid,
  output logic [MDATA_WIDTH-1:0] c1_rsp_mdata,
  output logic                   overflow_err
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ALM  = c_CNT_W'(FIFO_DEPTH - ALM_FULL_SLACK);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  logic [511:0]            r_mem       [2**MEM_IDX_BITS];
  logic [MEM_IDX_BITS-1:0] r_rdq_idx   [FIFO_DEPTH];
  logic [MDATA_WIDTH-1:0]  r_rdq_mdata [FIFO_DEPTH];
  logic [MDATA_WIDTH-1:0]  r_wrq_mdata [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_rdq_wptr, r_rdq_rptr, r_wrq_wptr, r_wrq_rptr;
  logic [c_CNT_W-1:0]      r_rdq_cnt, r_wrq_cnt;
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [MDATA_WIDTH-1:0]  r_pipe_mdata [READ_LATENCY];
  logic [511:0]            r_pipe_data  [READ_LATENCY];
  logic                    r_c0_alm, r_c1_alm, r_c1_rsp_vld, r_ovf;
  logic [MDATA_WIDTH-1:0]  r_c1_rsp_mdata;

  logic                    w_c0_push, w_c0_pop, w_c1_push, w_c1_pop;
  logic [MEM_IDX_BITS-1:0] w_rd_idx, w_wr_idx, w_pop_idx;
  logic [511:0]            w_pop_data;
  logic [c_CNT_W-1:0]      w_rdq_cnt_nxt, w_wrq_cnt_nxt;
  logic                    w_addr_unused;

  // Upper address bits alias onto the same line by design.
  assign w_rd_idx      = c0_req_addr[MEM_IDX_BITS-1:0];
  assign w_wr_idx      = c1_req_addr[MEM_IDX_BITS-1:0];
  assign w_addr_unused = ^{c0_req_addr[ADDR_WIDTH-1:MEM_IDX_BITS],
                           c1_req_addr[ADDR_WIDTH-1:MEM_IDX_BITS]};

  assign w_c0_pop  = (r_rdq_cnt != c_CNT_ZERO);
  assign w_c1_pop  = (r_wrq_cnt != c_CNT_ZERO);
  assign w_c0_push = c0_req_valid && !reset && ((r_rdq_cnt != c_CNT_FULL) || w_c0_pop);
  assign w_c1_push = c1_req_valid && !reset && ((r_wrq_cnt != c_CNT_FULL) || w_c1_pop);

  assign w_rdq_cnt_nxt = r_rdq_cnt + c_CNT_W'(w_c0_push) - c_CNT_W'(w_c0_pop);
  assign w_wrq_cnt_nxt = r_wrq_cnt + c_CNT_W'(w_c1_push) - c_CNT_W'(w_c1_pop);

  // A write landing in the pop cycle must be visible to that read.
  assign w_pop_idx  = r_rdq_idx[r_rdq_rptr];
  assign w_pop_data = (w_c1_push && (w_wr_idx == w_pop_idx)) ? c1_req_data : r_mem[w_pop_idx];

  always_ff @(posedge clk) begin
    if (w_c1_push) begin
      r_mem[w_wr_idx]         <= c1_req_data;
      r_wrq_mdata[r_wrq_wptr] <= c1_req_mdata;
    end
    if (w_c0_push) begin
      r_rdq_idx[r_rdq_wptr]   <= w_rd_idx;
      r_rdq_mdata[r_rdq_wptr] <= c0_req_mdata;
    end
  end

  always_ff @(posedge clk) begin
    r_c1_rsp_mdata  <= r_wrq_mdata[r_wrq_rptr];
    r_pipe_mdata[0] <= r_rdq_mdata[r_rdq_rptr];
    r_pipe_data[0]  <= w_pop_data;
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_pipe_mdata[i] <= r_pipe_mdata[i-1];
      r_pipe_data[i]  <= r_pipe_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdq_wptr   <= '0;
      r_rdq_rptr   <= '0;
      r_rdq_cnt    <= '0;
      r_wrq_wptr   <= '0;
      r_wrq_rptr   <= '0;
      r_wrq_cnt    <= '0;
      r_pipe_vld   <= '0;
      r_c1_rsp_vld <= 1'b0;
      r_ovf        <= 1'b0;
      r_c0_alm     <= 1'b1;
      r_c1_alm     <= 1'b1;
    end else begin
      if (w_c0_push) r_rdq_wptr <= r_rdq_wptr + c_PTR_ONE;
      if (w_c0_pop)  r_rdq_rptr <= r_rdq_rptr + c_PTR_ONE;
      if (w_c1_push) r_wrq_wptr <= r_wrq_wptr + c_PTR_ONE;
      if (w_c1_pop)  r_wrq_rptr <= r_wrq_rptr + c_PTR_ONE;
      r_rdq_cnt    <= w_rdq_cnt_nxt;
      r_wrq_cnt    <= w_wrq_cnt_nxt;
      r_pipe_vld   <= (r_pipe_vld << 1) | READ_LATENCY'(w_c0_pop);
      r_c1_rsp_vld <= w_c1_pop;
      r_c0_alm     <= (w_rdq_cnt_nxt >= c_CNT_ALM);
      r_c1_alm     <= (w_wrq_cnt_nxt >= c_CNT_ALM);
      if ((c0_req_valid && !w_c0_push) || (c1_req_valid && !w_c1_push)) r_ovf <= 1'b1;
    end
  end

  assign c0TxAlmFull  = r_c0_alm;
  assign c1TxAlmFull  = r_c1_alm;
  assign c0_rsp_valid = r_pipe_vld[READ_LATENCY-1];
  assign c0_rsp_mdata = r_pipe_mdata[READ_LATENCY-1];
  assign c0_rsp_data  = r_pipe_data[READ_LATENCY-1];
  assign c1_rsp_valid = r_c1_rsp_vld;
  assign c1_rsp_mdata = r_c1_rsp_mdata;
  assign overflow_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_sim_fiu_responder.sv
`default_nettype none
// Randomized scoreboard bench for cci_mpf_sim_fiu_responder against a line-memory reference model.
module tb_cci_mpf_sim_fiu_responder;
  localparam int AW = 42, MW = 16, IB = 10, DEPTH = 64, SLACK = 8, LAT = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           c0_req_valid = 1'b0;
  logic [AW-1:0]  c0_req_addr = '0;
  logic [MW-1:0]  c0_req_mdata = '0;
  logic           c1_req_valid = 1'b0;
  logic [AW-1:0]  c1_req_addr = '0;
  logic [MW-1:0]  c1_req_mdata = '0;
  logic [511:0]   c1_req_data = '0;
  logic           c0TxAlmFull, c1TxAlmFull, c0_rsp_valid, c1_rsp_valid, overflow_err;
  logic [MW-1:0]  c0_rsp_mdata, c1_rsp_mdata;
  logic [511:0]   c0_rsp_data;

  always #5 clk = ~clk;

  cci_mpf_sim_fiu_responder dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
    .c1_req_data(c1_req_data),
    .c0TxAlmFull(c0TxAlmFull), .c1TxAlmFull(c1TxAlmFull),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .overflow_err(overflow_err)
  );

  typedef struct { logic [MW-1:0] mdata; logic [511:0] data; int due; } rd_exp_t;
  rd_exp_t       rd_q[$];
  logic [MW-1:0] wr_q[$];
  logic [511:0]  ref_mem [int];
  int            cyc = 0, checks = 0, failures = 0;
  bit            pend_v = 1'b0;
  int            pend_i = 0, pend_due = 0;
  logic [MW-1:0] pend_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    rd_exp_t e;
    logic [MW-1:0] m;
    if (c0_rsp_valid === 1'b1) begin
      if (rd_q.size() == 0) chk("c0_unexpected_rsp", 512'(c0_rsp_valid), 512'(0));
      else begin
        e = rd_q.pop_front();
        chk("c0_mdata", 512'(c0_rsp_mdata), 512'(e.mdata));
        chk("c0_data", c0_rsp_data, e.data);
        if (e.due >= 0) chk("c0_latency", 512'(cyc), 512'(e.due));
      end
    end
    if (c1_rsp_valid === 1'b1) begin
      if (wr_q.size() == 0) chk("c1_unexpected_rsp", 512'(c1_rsp_valid), 512'(0));
      else begin
        m = wr_q.pop_front();
        chk("c1_mdata", 512'(c1_rsp_mdata), 512'(m));
      end
    end
  end

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] rnd_addr(input int idx);
    logic [63:0] r;
    logic [AW-1:0] a;
    r = {$urandom, $urandom};
    a = r[AW-1:0];
    a[IB-1:0] = idx[IB-1:0];
    return a;
  endfunction

  // Reference: writes land first; a read issued last cycle sees memory as of this cycle.
  task automatic issue(input bit rv, input logic [AW-1:0] ra, input logic [MW-1:0] rm,
                       input bit wv, input logic [AW-1:0] wa, input logic [MW-1:0] wm,
                       input logic [511:0] wd);
    c0_req_valid = rv; c0_req_addr = ra; c0_req_mdata = rm;
    c1_req_valid = wv; c1_req_addr = wa; c1_req_mdata = wm; c1_req_data = wd;
    if (wv) begin
      ref_mem[int'(wa[IB-1:0])] = wd;
      wr_q.push_back(wm);
    end
    if (pend_v) begin
      rd_q.push_back(rd_exp_t'{mdata: pend_m, data: ref_mem[pend_i], due: pend_due});
      pend_v = 1'b0;
    end
    if (rv) begin
      pend_v = 1'b1; pend_i = int'(ra[IB-1:0]); pend_m = rm; pend_due = cyc + 1 + LAT;
    end
    @(posedge clk); #1;
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;
  endtask

  task automatic idle();
    issue(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || pend_v) && n < 400) begin
      idle(); n++;
    end
    chk("drain_complete", 512'(rd_q.size() + wr_q.size()), 512'(0));
    repeat (4) idle();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; c0_req_valid = 1'b0; c1_req_valid = 1'b0;
    @(posedge clk); #1;
    rd_q.delete(); wr_q.delete(); pend_v = 1'b0;
    chk("rst_c0_alm", 512'(c0TxAlmFull), 512'(1));
    chk("rst_c1_alm", 512'(c1TxAlmFull), 512'(1));
    chk("rst_valids", 512'({c0_rsp_valid, c1_rsp_valid}), 512'(0));
    chk("rst_overflow", 512'(overflow_err), 512'(0));
    repeat (n - 1) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_alm", 512'({c0TxAlmFull, c1TxAlmFull}), 512'(0));
  endtask

  // Pop side is held off externally, so expectations follow plain FIFO capacity.
  task automatic blk_read(input int k);
    int idx;
    idx = int'($urandom_range(0, 2**IB - 1));
    c0_req_valid = 1'b1; c0_req_addr = rnd_addr(idx); c0_req_mdata = MW'(k);
    if (k <= DEPTH) rd_q.push_back(rd_exp_t'{mdata: MW'(k), data: ref_mem[idx], due: -1});
    @(posedge clk); #1;
    c0_req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [511:0] d;
    do_reset(3);
    // Memory is not cleared by reset, so give every line a known value.
    for (int i = 0; i < 2**IB; i++) issue(1'b0, '0, '0, 1'b1, rnd_addr(i), MW'(i), rnd512());
    drain();

    issue(1'b0, '0, '0, 1'b1, 42'h5, 16'h11, {64{8'hA5}});
    issue(1'b1, 42'h5, 16'h22, 1'b0, '0, '0, '0);
    drain();

    d = rnd512();
    issue(1'b1, 42'h7, 16'h33, 1'b1, 42'h7, 16'h34, d);
    issue(1'b1, 42'h8, 16'h35, 1'b0, '0, '0, '0);
    issue(1'b0, '0, '0, 1'b1, 42'h8, 16'h36, rnd512());
    drain();

    issue(1'b0, '0, '0, 1'b1, 42'h405, 16'h44, rnd512());
    issue(1'b1, 42'h005, 16'h45, 1'b0, '0, '0, '0);
    drain();

    for (int k = 0; k < 64; k++) begin
      issue(1'b1, rnd_addr(int'($urandom_range(0, 2**IB - 1))), MW'(16'h100 + k), 1'b0, '0, '0, '0);
      chk("b2b_alm", 512'(c0TxAlmFull), 512'(0));
    end
    drain();
    chk("b2b_overflow", 512'(overflow_err), 512'(0));

    for (int k = 0; k < 600; k++) begin
      int ri, wi;
      ri = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2**IB - 1)) : int'($urandom_range(0, 15));
      wi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2**IB - 1)) : int'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), rnd_addr(ri), MW'($urandom),
            1'($urandom_range(0, 1)), rnd_addr(wi), MW'($urandom), rnd512());
    end
    drain();

    force dut.w_c0_pop = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      blk_read(k);
      if (k == DEPTH - SLACK - 1) chk("alm_before_thresh", 512'(c0TxAlmFull), 512'(0));
      if (k == DEPTH - SLACK)     chk("alm_at_thresh", 512'(c0TxAlmFull), 512'(1));
      if (k == DEPTH)             chk("ovf_at_full", 512'(overflow_err), 512'(0));
      if (k == DEPTH + 1)         chk("ovf_on_drop", 512'(overflow_err), 512'(1));
    end
    release dut.w_c0_pop;
    drain();
    chk("ovf_sticky", 512'(overflow_err), 512'(1));
    chk("alm_after_drain", 512'(c0TxAlmFull), 512'(0));

    do_reset(2);
    force dut.w_c1_pop = 1'b0;
    d = rnd512();
    issue(1'b1, rnd_addr(3), 16'h301, 1'b1, 42'h20, 16'h0A01, d);
    issue(1'b1, rnd_addr(4), 16'h302, 1'b1, 42'h21, 16'h0A02, rnd512());
    issue(1'b1, rnd_addr(5), 16'h303, 1'b0, '0, '0, '0);
    do_reset(2);
    release dut.w_c1_pop;
    repeat (12) idle();
    issue(1'b1, 42'h20, 16'h501, 1'b0, '0, '0, '0);
    issue(1'b1, 42'h21, 16'h502, 1'b0, '0, '0, '0);
    drain();
    chk("preserved_line", ref_mem[32], d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
